// File: rtl/sent_pkg.sv
// rtl/sent_pkg.sv - shared types and CRC constants for the SENT CRC scheduler
// SENT_CRC_ENHANCED_EN selects whether the enhanced-serial/CRC6 path exists.
package sent_pkg;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;
  typedef enum logic [1:0] {FAST, SER, ENH} req_id_e;

  localparam logic [4:0] CRC4_POLY = 5'h1D;
  localparam logic [6:0] CRC6_POLY = 7'h59;
  localparam logic [3:0] CRC4_SEED = 4'h5;
  localparam logic [5:0] CRC6_SEED = 6'h15;

`ifdef SENT_CRC_ENHANCED_EN
  localparam bit ENH_EN = 1'b1;
`else
  localparam bit ENH_EN = 1'b0;
`endif

endpackage

// File: rtl/sent_crc_step.sv
// rtl/sent_crc_step.sv - one chunk step r_next = (r*x^w + chunk) mod P, bit-unrolled
// CRC6 half exists only with SENT_CRC_ENHANCED_EN.
module sent_crc_step
  import sent_pkg::*;
(
  input  logic [5:0] r,
  input  logic [5:0] chunk,
  input  logic       wide,
  output logic [5:0] r_next
);

  logic [3:0] r4;
`ifdef SENT_CRC_ENHANCED_EN
  logic [5:0] r6;
`else
  logic unused_hi;
  assign unused_hi = ^{wide, r[5:4], chunk[5:4]};
`endif

  always_comb begin
    // Each bit: multiply by x, bring in the next chunk bit, reduce on overflow.
    r4 = r[3:0];
    for (int i = 3; i >= 0; i--) begin
      r4 = {r4[2:0], chunk[i]} ^ (r4[3] ? CRC4_POLY[3:0] : 4'h0);
    end
`ifdef SENT_CRC_ENHANCED_EN
    r6 = r;
    for (int i = 5; i >= 0; i--) begin
      r6 = {r6[4:0], chunk[i]} ^ (r6[5] ? CRC6_POLY[5:0] : 6'h00);
    end
    r_next = wide ? r6 : {2'b00, r4};
`else
    r_next = {2'b00, r4};
`endif
  end

endmodule

// File: rtl/sent_tx_crc_sched.sv
// rtl/sent_tx_crc_sched.sv - shared sequenced CRC4/CRC6 engine with fixed-priority arbitration
// Enhanced-serial requester and CRC6 output are active only with SENT_CRC_ENHANCED_EN.
module sent_tx_crc_sched
  import sent_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        fast_req,
  input  logic [2:0]  fast_nib_cnt,
  input  logic [23:0] fast_data,
  input  logic        ser_req,
  input  logic [11:0] ser_data,
  input  logic        enh_req,
  input  logic [23:0] enh_data,
  output logic        fast_gnt,
  output logic        ser_gnt,
  output logic        enh_gnt,
  output logic        fast_done,
  output logic        ser_done,
  output logic        enh_done,
  output logic [3:0]  crc4_out,
  output logic [5:0]  crc6_out,
  output logic        busy
);

  state_e      state;
  req_id_e     owner;
  logic [2:0]  count;
  logic [2:0]  n_chunks;
  logic [23:0] shreg;
  logic        wide;
  logic [5:0]  r;
  logic [5:0]  r_next;
  logic [5:0]  chunk;
  logic [5:0]  crc6_reg;
  logic        enh_done_reg;
  logic        fast_win;
  logic        ser_win;
  logic        enh_win;

  // Grant is combinational so it lands in the same IDLE cycle the request is sampled.
  assign fast_win = (state == IDLE) && !reset && fast_req;
  assign ser_win  = (state == IDLE) && !reset && ser_req && !fast_req;
  assign enh_win  = ENH_EN && (state == IDLE) && !reset && enh_req && !fast_req && !ser_req;

  assign fast_gnt = fast_win;
  assign ser_gnt  = ser_win;
  assign enh_gnt  = enh_win;
  assign enh_done = ENH_EN && enh_done_reg;
  assign crc6_out = ENH_EN ? crc6_reg : 6'h00;

  // Data is left-aligned in shreg, so the next chunk is always at the top.
  always_comb begin
    chunk = 6'h00;
    if (count < n_chunks) begin
      chunk = wide ? shreg[23:18] : {2'b00, shreg[23:20]};
    end
  end

  sent_crc_step u_step (
    .r      (r),
    .chunk  (chunk),
    .wide   (wide),
    .r_next (r_next)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      owner        <= FAST;
      count        <= 3'd0;
      n_chunks     <= 3'd0;
      shreg        <= 24'h0;
      wide         <= 1'b0;
      r            <= 6'h00;
      crc4_out     <= 4'h0;
      crc6_reg     <= 6'h00;
      fast_done    <= 1'b0;
      ser_done     <= 1'b0;
      enh_done_reg <= 1'b0;
      busy         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (fast_win) begin
            owner <= FAST;
            wide  <= 1'b0;
            r     <= {2'b00, CRC4_SEED};
            case (fast_nib_cnt)
              3'd3: begin
                n_chunks <= 3'd3;
                shreg    <= {fast_data[11:0], 12'h000};
              end
              3'd4: begin
                n_chunks <= 3'd4;
                shreg    <= {fast_data[15:0], 8'h00};
              end
              default: begin
                n_chunks <= 3'd6;
                shreg    <= fast_data;
              end
            endcase
          end else if (ser_win) begin
            owner    <= SER;
            wide     <= 1'b0;
            r        <= {2'b00, CRC4_SEED};
            n_chunks <= 3'd3;
            shreg    <= {ser_data, 12'h000};
          end else if (enh_win) begin
            owner    <= ENH;
            wide     <= 1'b1;
            r        <= CRC6_SEED;
            n_chunks <= 3'd4;
            shreg    <= enh_data;
          end
          if (fast_win || ser_win || enh_win) begin
            count <= 3'd0;
            state <= CALC;
            busy  <= 1'b1;
          end
        end
        CALC: begin
          r     <= r_next;
          shreg <= wide ? (shreg << 6) : (shreg << 4);
          count <= count + 3'd1;
          // Chunk n_chunks is the zero augment; its result is the final CRC.
          if (count == n_chunks) begin
            state <= DONE;
            if (wide) crc6_reg <= r_next;
            else      crc4_out <= r_next[3:0];
            fast_done    <= (owner == FAST);
            ser_done     <= (owner == SER);
            enh_done_reg <= (owner == ENH);
          end
        end
        DONE: begin
          fast_done    <= 1'b0;
          ser_done     <= 1'b0;
          enh_done_reg <= 1'b0;
          busy         <= 1'b0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
